// File: rtl/stall_pkg.sv
// stall_pkg: shared widths, FSM states and round-robin selection for the stall timer
package stall_pkg;
  localparam int STALL_WIDTH = 28;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} stall_state_t;
  // first set bit after last, wrapping mod n; returns last when nothing is set
  function automatic logic [IDX_W-1:0] rr_pick(input logic [7:0] req, input logic [IDX_W-1:0] last, input int n);
    logic [IDX_W-1:0] idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % n);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/stall_downcounter.sv
// stall_downcounter: loadable down-counter saturating at zero; load wins over decrement
module stall_downcounter import stall_pkg::*; #(
  parameter int WIDTH = STALL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             is_one
);
  always_ff @(posedge clk)
    if (reset) value <= '0;
    else if (load) value <= load_val;
    else if (en && value != '0) value <= value - WIDTH'(1);
  assign is_one = value == WIDTH'(1);
endmodule

// File: rtl/stall_timer_arbiter.sv
// stall_timer_arbiter: round-robin owner of one shared stall down-counter.
// Define STALL_ABORT_EN to add the aborted output and abandon a count when the owner drops req.
module stall_timer_arbiter import stall_pkg::*; #(
  parameter int NREQ  = 3,
  parameter int WIDTH = STALL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dur,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      remaining
`ifdef STALL_ABORT_EN
  ,
  output logic                  aborted
`endif
);
  stall_state_t state;
  logic [IDX_W-1:0] last, pick;
  logic [WIDTH-1:0] dur_sel;
  logic is_one, abort, load;
  assign pick = rr_pick(8'(req), last, NREQ);
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < NREQ; i++) if (pick == IDX_W'(i)) dur_sel = dur[i*WIDTH +: WIDTH];
  end
`ifdef STALL_ABORT_EN
  assign abort = state == COUNT && !(|(req & grant));
`else
  assign abort = 1'b0;
`endif
  assign load = (state == IDLE && |req) || abort;
  assign busy = state != IDLE;
  stall_downcounter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(abort ? '0 : dur_sel),
    .en(state == COUNT),
    .value(remaining),
    .is_one(is_one)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      done <= '0;
      last <= IDX_W'(NREQ - 1);
`ifdef STALL_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef STALL_ABORT_EN
      aborted <= abort;
`endif
      if (state == IDLE) begin
        if (|req) begin
          last <= pick;
          grant <= NREQ'(1) << pick;
          state <= dur_sel != '0 ? COUNT : DONE;
          done <= dur_sel != '0 ? '0 : NREQ'(1) << pick;
        end
      end else if (state == COUNT) begin
        if (abort) begin
          state <= IDLE;
          grant <= '0;
        end else if (is_one) begin
          state <= DONE;
          done <= grant;
        end
      end else begin
        state <= IDLE;
        grant <= '0;
      end
    end
endmodule
